// File: rtl/riscv_defines.sv
`default_nettype none
// ============================================================================
// Module      : riscv_defines (package)
// Description : Shared definitions for the instruction prefetch path.
//               It holds the default datapath width and the prefetch FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_defines;

  // Default width of instructions and addresses.
  localparam int WORD_WIDTH = 32;

  // Prefetch FSM states:
  //   IDLE - no transaction outstanding, no request on the bus
  //   REQ  - request driven, waiting for the grant
  //   WAIT - request granted, waiting for the read data
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } prefetch_state_e;

endpackage : riscv_defines
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO that stores prefetched {instruction, pc}
//               entries. A flush empties it on the next edge and overrides
//               any push or pop in the same cycle. A push and a pop in the
//               same cycle are both performed, even when the FIFO is full.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               flush_i       - discard all entries
//               push_i/data_i - write one entry
//               pop_i         - drop the head entry
//               data_o        - head entry (undefined when empty)
//               full_o/empty_o/count_o - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop   = pop_i && !flush_i && (count_q != '0);
    // A full FIFO only accepts a write when the head leaves in the same cycle.
    do_push  = push_i && !flush_i && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap modulo DEPTH naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_buffer
// Description : Instruction prefetcher. It issues sequential word fetches
//               over a req/gnt/rvalid bus, with at most one transaction
//               outstanding, and queues the returned {instr, pc} pairs in a
//               fetch_fifo for the IF stage. A branch flushes the queue and
//               redirects fetching. A response that is still in flight when
//               the branch arrives is dropped.
// Ports       : clk, rst                        - clock, async active-high reset
//               instr_req_o/instr_addr_o        - memory request / address
//               instr_gnt_i                     - request accepted
//               instr_rvalid_i/instr_rdata_i    - read response
//               fetch_en_i                      - allow new requests
//               pc_start_address_i              - boot address
//               branch_i/branch_addr_i          - redirect
//               valid_o/ready_i                 - IF-stage handshake
//               instr_o/pc_o                    - head instruction and pc
// Config      : PREFETCH_BYPASS_EN - when defined, a response that arrives
//               while the queue is empty and the IF stage is ready is
//               forwarded combinationally (zero latency) instead of queued.
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_buffer
  import riscv_defines::*;
#(
  parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  input  logic                  fetch_en_i,
  input  logic [WORD_WIDTH-1:0] pc_start_address_i,
  input  logic                  branch_i,
  input  logic [WORD_WIDTH-1:0] branch_addr_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [WORD_WIDTH-1:0] instr_o,
  output logic [WORD_WIDTH-1:0] pc_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 2 * WORD_WIDTH;

  prefetch_state_e       state_q, state_d;
  logic [WORD_WIDTH-1:0] fetch_addr_q, fetch_addr_d;  // next address to request
  logic [WORD_WIDTH-1:0] req_addr_q, req_addr_d;      // address of granted request
  logic [WORD_WIDTH-1:0] redir_addr_q, redir_addr_d;  // target of a branch taken in REQ
  logic                  redir_pend_q, redir_pend_d;
  logic                  discard_q, discard_d;        // drop the next response
  logic                  started_q, started_d;        // first grant or branch seen

  logic                  granted;
  logic                  resp_in;
  logic                  outstanding_after;
  logic                  bypass;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         count_next;
  logic [EW-1:0]         fifo_rdata;

  // --------------------------------------------------------------------------
  // Bus events
  // --------------------------------------------------------------------------
  always_comb begin
    granted = (state_q == REQ) && instr_gnt_i;
    // Responses only count while a transaction is in flight, so a late
    // rvalid after a reset is ignored.
    resp_in = (state_q == WAIT) && instr_rvalid_i;
    // A transaction will still be in flight after this edge.
    outstanding_after = (state_q == REQ) || ((state_q == WAIT) && !instr_rvalid_i);
  end

`ifdef PREFETCH_BYPASS_EN
  assign bypass = fifo_empty && resp_in && !discard_q && ready_i && !branch_i;
`else
  assign bypass = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Queue control. A branch cancels both the push and the pop of its cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    fifo_push  = resp_in && !discard_q && !branch_i && !bypass;
    fifo_pop   = !fifo_empty && ready_i && !branch_i;
    count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (branch_i),
    .push_i  (fifo_push),
    .data_i  ({instr_rdata_i, req_addr_q}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // --------------------------------------------------------------------------
  // FSM next state and request output
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    instr_req_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fetch_en_i && !fifo_full && !branch_i) state_d = REQ;
      end
      REQ: begin
        instr_req_o = 1'b1;
        if (instr_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (instr_rvalid_i) begin
          // After a redirect or a dropped response, restart from IDLE so
          // the next request uses the new fetch address.
          if (branch_i || discard_q)                            state_d = IDLE;
          else if (fetch_en_i && (count_next < CW'(DEPTH)))     state_d = REQ;
          else                                                  state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Address tracking and discard bookkeeping
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    req_addr_d   = req_addr_q;
    redir_addr_d = redir_addr_q;
    redir_pend_d = redir_pend_q;
    discard_d    = discard_q;
    started_d    = started_q;

    if (granted) begin
      req_addr_d = fetch_addr_q;
      started_d  = 1'b1;
    end

    if (branch_i) begin
      // A branch also ends boot-address tracking, so the target is kept.
      started_d = 1'b1;
      if ((state_q == REQ) && !instr_gnt_i) begin
        // The ungranted request must keep its address; park the target
        // and apply it once the grant arrives.
        redir_pend_d = 1'b1;
        redir_addr_d = branch_addr_i;
      end else begin
        fetch_addr_d = branch_addr_i;
        redir_pend_d = 1'b0;
      end
    end else if (granted) begin
      fetch_addr_d = redir_pend_q ? redir_addr_q : (fetch_addr_q + WORD_WIDTH'(4));
      redir_pend_d = 1'b0;
    end else if (!started_q) begin
      fetch_addr_d = pc_start_address_i;
    end

    // Only mark a response for dropping if one is still to come; a branch
    // coinciding with rvalid already cancels that push directly.
    if (branch_i && outstanding_after) discard_d = 1'b1;
    else if (resp_in)                  discard_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      req_addr_q   <= '0;
      redir_addr_q <= '0;
      redir_pend_q <= 1'b0;
      discard_q    <= 1'b0;
      started_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      req_addr_q   <= req_addr_d;
      redir_addr_q <= redir_addr_d;
      redir_pend_q <= redir_pend_d;
      discard_q    <= discard_d;
      started_q    <= started_d;
    end
  end

  assign instr_addr_o = fetch_addr_q;

  // --------------------------------------------------------------------------
  // IF-stage outputs; forced to zero when nothing is valid.
  // --------------------------------------------------------------------------
  always_comb begin
    valid_o = !fifo_empty;
    instr_o = '0;
    pc_o    = '0;
    if (bypass) begin
      valid_o = 1'b1;
      instr_o = instr_rdata_i;
      pc_o    = req_addr_q;
    end else if (!fifo_empty) begin
      {instr_o, pc_o} = fifo_rdata;
    end
  end

endmodule : prefetch_buffer
`default_nettype wire

// File: tb/tb_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_prefetch_buffer
// Description : Self-checking bench for prefetch_buffer. A memory responder
//               with programmable grant/response delays feeds the DUT. The
//               reference model treats the consumed instructions as a stream
//               that starts at the boot address, steps by 4 and restarts at
//               each branch target. Every consumed pc/instr must match it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prefetch_buffer;

`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] PC_START = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        fetch_en_i;
  logic [31:0] pc_start_address_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  always #5 clk = ~clk;

  prefetch_buffer #(.WORD_WIDTH(32), .DEPTH(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .instr_req_o        (instr_req_o),
    .instr_addr_o       (instr_addr_o),
    .instr_gnt_i        (instr_gnt_i),
    .instr_rvalid_i     (instr_rvalid_i),
    .instr_rdata_i      (instr_rdata_i),
    .fetch_en_i         (fetch_en_i),
    .pc_start_address_i (pc_start_address_i),
    .branch_i           (branch_i),
    .branch_addr_i      (branch_addr_i),
    .valid_o            (valid_o),
    .ready_i            (ready_i),
    .instr_o            (instr_o),
    .pc_o               (pc_o)
  );

  int tests = 0;
  int fails = 0;

  // memory responder state
  bit          outstanding = 1'b0;
  logic [31:0] out_addr = '0;
  int          rv_cnt = 0;
  int          g_cnt = 0;
  int          gnt_dly = 0;
  int          rv_dly = 1;
  bit          rnd_mode = 1'b0;
  logic [31:0] grants[$];
  bit          prev_req_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  bit          saw_rvalid = 1'b0;
  logic        valid_at_rv = 1'b0;

  // stream model
  logic [31:0] exp_pc = PC_START;
  int          n_consumed = 0;
  bit          track_first = 1'b0;
  logic [31:0] first_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] r;
    r = (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the memory side, sample at the falling edge,
  // update models, return 1 time unit after the next rising edge.
  task automatic tick();
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    if (outstanding && rv_cnt == 0) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mem_word(out_addr);
    end
    if (instr_req_o && g_cnt == 0) instr_gnt_i = 1'b1;

    @(negedge clk);
    saw_rvalid = instr_rvalid_i;
    if (instr_rvalid_i) valid_at_rv = valid_o;
    if (prev_req_wait) begin
      check1("req_held", instr_req_o, 1'b1);
      check("addr_held", instr_addr_o, prev_addr);
    end
    if (valid_o && ready_i && !branch_i) begin
      check("pc_o", pc_o, exp_pc);
      check("instr_o", instr_o, mem_word(exp_pc));
      if (track_first) begin
        first_pc    = pc_o;
        track_first = 1'b0;
      end
      exp_pc = exp_pc + 32'd4;
      n_consumed++;
    end
    if (branch_i) exp_pc = branch_addr_i;

    if (instr_rvalid_i)   outstanding = 1'b0;
    else if (outstanding) rv_cnt--;

    if (instr_req_o && instr_gnt_i) begin
      check1("one_outstanding", outstanding, 1'b0);
      outstanding = 1'b1;
      out_addr    = instr_addr_o;
      grants.push_back(instr_addr_o);
      if (rnd_mode) begin
        gnt_dly = int'($urandom_range(0, 3));
        rv_dly  = int'($urandom_range(1, 3));
      end
      rv_cnt = rv_dly - 1;
      g_cnt  = gnt_dly;
    end else if (instr_req_o) begin
      g_cnt--;
    end else begin
      g_cnt = gnt_dly;
    end
    prev_req_wait = instr_req_o && !instr_gnt_i;
    prev_addr     = instr_addr_o;

    @(posedge clk);
    #1;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_req"}, instr_req_o, 1'b0);
    check({tag, "_addr"}, instr_addr_o, 32'h0);
    check1({tag, "_valid"}, valid_o, 1'b0);
    check({tag, "_instr"}, instr_o, 32'h0);
    check({tag, "_pc"}, pc_o, 32'h0);
  endtask

  initial begin
    int n;
    int gi;
    int cnt;
    logic [31:0] old_addr;

    rst                = 1'b1;
    fetch_en_i         = 1'b0;
    ready_i            = 1'b0;
    branch_i           = 1'b0;
    branch_addr_i      = '0;
    pc_start_address_i = PC_START;
    instr_gnt_i        = 1'b0;
    instr_rvalid_i     = 1'b0;
    instr_rdata_i      = '0;
    #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;

    // ---- sequential fetch from the boot address ----
    ready_i    = 1'b1;
    fetch_en_i = 1'b1;
    gnt_dly    = 1;
    g_cnt      = 1;
    rv_dly     = 1;
    exp_pc     = PC_START;
    rst        = 1'b0;
    n = 0;
    while (!saw_rvalid && n < 40) begin tick(); n++; end
    check1("first_resp_seen", saw_rvalid, 1'b1);
    check1("valid_in_rvalid_cycle", valid_at_rv, BYP);
    check1("valid_after_rvalid", valid_o, !BYP);
    n = 0;
    while ((grants.size() < 3 || n_consumed < 3) && n < 60) begin tick(); n++; end
    check1("boot_progress", (grants.size() >= 3) && (n_consumed >= 3), 1'b1);
    check("boot_addr0", grants[0], 32'h100);
    check("boot_addr1", grants[1], 32'h104);
    check("boot_addr2", grants[2], 32'h108);

    // ---- IF stalled: exactly DEPTH responses accepted ----
    ready_i       = 1'b0;
    gnt_dly       = 0;
    branch_i      = 1'b1;
    branch_addr_i = 32'h300;
    gi            = grants.size();
    tick();
    branch_i = 1'b0;
    repeat (40) tick();
    cnt = 0;
    for (int i = gi; i < grants.size(); i++)
      if (grants[i] >= 32'h300 && grants[i] < 32'h320) cnt++;
    check("stall_accepted", 32'(cnt), 32'd4);
    for (int i = 0; i < 6; i++) begin
      check1("stall_no_req", instr_req_o, 1'b0);
      tick();
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    n = 0;
    while (!instr_req_o && n < 3) begin tick(); n++; end
    check1("req_after_pop", instr_req_o, 1'b1);
    gi = grants.size();
    n = 0;
    while (grants.size() <= gi && n < 10) begin tick(); n++; end
    check("req_after_pop_addr", grants[gi], 32'h310);

    // ---- branch while in WAIT ----
    ready_i = 1'b1;
    rv_dly  = 3;
    n = 0;
    while (!outstanding && n < 40) begin tick(); n++; end
    check1("wait_reached", outstanding, 1'b1);
    branch_i      = 1'b1;
    branch_addr_i = 32'h200;
    gi            = grants.size();
    track_first   = 1'b1;
    tick();
    branch_i = 1'b0;
    check1("wait_branch_empty", valid_o, 1'b0);
    n = 0;
    while ((grants.size() <= gi || track_first) && n < 40) begin tick(); n++; end
    check("wait_branch_next_addr", grants[gi], 32'h200);
    check1("wait_branch_consumed", track_first, 1'b0);
    check("wait_branch_first_pc", first_pc, 32'h200);

    // ---- branch while in REQ with a slow grant ----
    rv_dly  = 1;
    gnt_dly = 3;
    n = 0;
    while (!instr_req_o && n < 40) begin tick(); n++; end
    check1("req_reached", instr_req_o, 1'b1);
    old_addr      = instr_addr_o;
    branch_i      = 1'b1;
    branch_addr_i = 32'h200;
    gi            = grants.size();
    track_first   = 1'b1;
    tick();
    branch_i = 1'b0;
    n = 0;
    while ((grants.size() < gi + 2 || track_first) && n < 60) begin tick(); n++; end
    check("req_branch_old_granted", grants[gi], old_addr);
    check("req_branch_new_addr", grants[gi + 1], 32'h200);
    check("req_branch_first_pc", first_pc, 32'h200);

    // ---- full queue streaming across the address wrap ----
    gnt_dly    = 0;
    fetch_en_i = 1'b0;
    repeat (10) tick();
    ready_i       = 1'b0;
    fetch_en_i    = 1'b1;
    branch_i      = 1'b1;
    branch_addr_i = 32'hFFFF_FFF0;
    gi            = grants.size();
    tick();
    branch_i = 1'b0;
    repeat (30) tick();
    check1("full_no_req", instr_req_o, 1'b0);
    check("full_count", 32'(grants.size() - gi), 32'd4);
    ready_i = 1'b1;
    repeat (30) tick();
    check("wrap_last", grants[gi + 3], 32'hFFFF_FFFC);
    check("wrap_zero", grants[gi + 4], 32'h0000_0000);

    // ---- reset in WAIT, stray response, then boot again ----
    rv_dly = 3;
    n = 0;
    while (!outstanding && n < 40) begin tick(); n++; end
    check1("wait_before_rst", outstanding, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    outstanding   = 1'b0;
    prev_req_wait = 1'b0;
    fetch_en_i    = 1'b0;
    exp_pc        = PC_START;
    tick();
    tick();
    rst = 1'b0;
    tick();
    outstanding = 1'b1;
    out_addr    = 32'hDEAD_0000;
    rv_cnt      = 0;
    tick();
    check1("stray_rvalid_seen", saw_rvalid, 1'b1);
    check1("stray_valid_same", valid_at_rv, 1'b0);
    check1("stray_valid_next", valid_o, 1'b0);
    check1("stray_no_req", instr_req_o, 1'b0);
    rv_dly     = 1;
    fetch_en_i = 1'b1;
    saw_rvalid = 1'b0;
    n = 0;
    while (!saw_rvalid && n < 40) begin tick(); n++; end
    check1("reboot_valid_in_rvalid", valid_at_rv, BYP);

    // ---- randomized traffic ----
    rnd_mode = 1'b1;
    cnt      = n_consumed;
    for (int i = 0; i < 1500; i++) begin
      ready_i    = ($urandom_range(0, 9) < 7);
      fetch_en_i = ($urandom_range(0, 9) < 9);
      branch_i   = ($urandom_range(0, 39) == 0);
      branch_addr_i = {$urandom(), 2'b00} >> 0;
      branch_addr_i[1:0] = 2'b00;
      tick();
      branch_i = 1'b0;
    end
    check1("random_progress", (n_consumed - cnt) > 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_prefetch_buffer
`default_nettype wire
